// File: rtl/rf_cmd_sequencer.sv
// rf_cmd_sequencer: accepts one ALU-style command at a time and runs it against a 32x16
// register file (read sources, compute, write back, report).
// Optional feature: define RF_CMD_SEQ_TIMEOUT_EN to abort register-file accesses that never
// complete within TIMEOUT_CYC cycles (pulses err and returns to idle without write-back).
module rf_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [15:0] cmd_imm,
    output logic [2:0]  rf_instr,
    output logic [4:0]  rf_read1,
    output logic [4:0]  rf_read2,
    output logic [4:0]  rf_write,
    output logic [15:0] rf_writed,
    input  logic [15:0] rf_readd1,
    input  logic [15:0] rf_readd2,
    input  logic        rf_done,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpOr   = 3'b100;
    localparam logic [2:0] OpXor  = 3'b101;
    localparam logic [2:0] OpAddi = 3'b110;
    localparam logic [2:0] OpLdi  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWrite,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [15:0] r_imm;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [15:0] r_wdata;
    logic [15:0] r_result;
    logic [15:0] w_alu;

    logic        w_accept;

    assign w_accept = (r_state == StIdle) && cmd_valid;

`ifdef RF_CMD_SEQ_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

    logic [WaitW-1:0] r_wait;
    logic             w_timeout;
    logic             r_err;

    // A done in the final allowed cycle still completes the access.
    assign w_timeout = ((r_state == StRead) || (r_state == StWrite)) && !rf_done &&
                       (r_wait == WaitLast);

    // Wait counter: restarts on every state change, counts only while an access is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_state_d != r_state) begin
            r_wait <= '0;
        end else if ((r_state == StRead) || (r_state == StWrite)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Abort pulse, registered so it appears in the first idle cycle after the abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    // The limit only matters when the timeout logic is built in.
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign err              = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_op == OpNop) begin
                        w_state_d = StDone;
                    end else if (cmd_op == OpLdi) begin
                        w_state_d = StExec;
                    end else begin
                        w_state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (rf_done) begin
                    w_state_d = StExec;
                end
`ifdef RF_CMD_SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_d = StIdle;
                end
`endif
            end
            StExec: begin
                w_state_d = StWrite;
            end
            StWrite: begin
                if (rf_done) begin
                    w_state_d = StDone;
                end
`ifdef RF_CMD_SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_d = StIdle;
                end
`endif
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Command fields are captured once at acceptance and held for the whole command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= OpNop;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= cmd_op;
            r_rd  <= cmd_rd;
            r_rs1 <= cmd_rs1;
            r_rs2 <= cmd_rs2;
            r_imm <= cmd_imm;
        end
    end

    // Operands are only valid in the cycle the register file reports done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa <= '0;
            r_opb <= '0;
        end else if ((r_state == StRead) && rf_done) begin
            r_opa <= rf_readd1;
            r_opb <= rf_readd2;
        end
    end

    // ALU, evaluated on the latched operands.
    always_comb begin
        w_alu = 16'h0000;
        unique case (r_op)
            OpAdd:   w_alu = r_opa + r_opb;
            OpSub:   w_alu = r_opa - r_opb;
            OpAnd:   w_alu = r_opa & r_opb;
            OpOr:    w_alu = r_opa | r_opb;
            OpXor:   w_alu = r_opa ^ r_opb;
            OpAddi:  w_alu = r_opa + r_imm;
            OpLdi:   w_alu = r_imm;
            default: w_alu = 16'h0000;
        endcase
    end

    // Write-back data is computed in EXEC; the visible result only changes once the write
    // has been acknowledged, so an aborted command never disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata  <= '0;
            r_result <= '0;
        end else begin
            if (r_state == StExec) begin
                r_wdata <= w_alu;
            end
            if ((r_state == StWrite) && rf_done) begin
                r_result <= r_wdata;
            end
        end
    end

    // Register-file request, decoded from state so it drops the cycle after done.
    always_comb begin
        rf_instr = 3'b000;
        unique case (r_state)
            StRead:  rf_instr = (r_op == OpAddi) ? 3'b100 : 3'b110;
            StWrite: rf_instr = 3'b001;
            default: rf_instr = 3'b000;
        endcase
    end

    assign rf_read1     = r_rs1;
    assign rf_read2     = r_rs2;
    assign rf_write     = r_rd;
    assign rf_writed    = r_wdata;
    assign result       = r_result;
    assign result_valid = (r_state == StDone);
    assign cmd_ready    = (r_state == StIdle);
    assign busy         = (r_state != StIdle);

endmodule
